// File: rtl/t04_fb_pkg.sv
// Shared types and default sizes for the frame-buffer arbiter slice.
//   state_e  : clear sequencer states
//   owner_e  : which requester owns the RAM port this cycle
package t04_fb_pkg;

    localparam int unsigned FB_ADDR_W = 12;
    localparam int unsigned FB_DATA_W = 8;
    localparam int unsigned FB_WORDS  = 3072;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_CLR,
        OWN_WR
    } owner_e;

endpackage

// File: rtl/t04_fb_arbiter_if.sv
// Requester and RAM-side signals of the frame-buffer arbiter.
//   master : display / writer / clear-button / RAM environment
//   slave  : the arbiter
interface t04_fb_arbiter_if #(
    parameter int unsigned ADDR_W = t04_fb_pkg::FB_ADDR_W,
    parameter int unsigned DATA_W = t04_fb_pkg::FB_DATA_W
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_rdata;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              clr_start;
    logic              clr_busy;
    logic              wr_drop;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output disp_req, disp_addr, wr_req, wr_addr, wr_data, clr_start, mem_rdata,
        input  disp_valid, disp_rdata, wr_ack, clr_busy, wr_drop,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  disp_req, disp_addr, wr_req, wr_addr, wr_data, clr_start, mem_rdata,
        output disp_valid, disp_rdata, wr_ack, clr_busy, wr_drop,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/t04_fb_clear_seq.sv
// Full-screen clear sequencer: walks addresses 0..FB_WORDS-1 once per go.
//   clk, reset : clock, synchronous active-high reset
//   go         : start pulse, honoured only in IDLE
//   stall      : hold the counter this cycle (port taken by display)
//   busy       : clear in progress (registered state)
//   addr       : address of the word being cleared
//   we         : a zero write to addr happens this cycle
module t04_fb_clear_seq #(
    parameter int unsigned ADDR_W   = t04_fb_pkg::FB_ADDR_W,
    parameter int unsigned FB_WORDS = t04_fb_pkg::FB_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              stall,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic              we
);
    import t04_fb_pkg::*;

    // Terminate on an explicit compare so FB_WORDS = 2**ADDR_W never wraps.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, counter advance and write strobe
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we        = 1'b0;
        busy      = (state == CLEAR);
        addr      = cnt;
        unique case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (!stall) begin
                    we = 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + ADDR_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/t04_fb_arbiter.sv
// Single-port frame-buffer arbiter: display > clear > writer, granted per cycle.
//   clk, reset : clock, synchronous active-high reset
//   bus        : display read, pixel writer, clear control and RAM port
// The grant and mem_* drive are combinational from the current requests;
// disp_valid, wr_drop and the clear state are registered.
module t04_fb_arbiter #(
    parameter int unsigned ADDR_W   = t04_fb_pkg::FB_ADDR_W,
    parameter int unsigned DATA_W   = t04_fb_pkg::FB_DATA_W,
    parameter int unsigned FB_WORDS = t04_fb_pkg::FB_WORDS
) (
    input  logic             clk,
    input  logic             reset,
    t04_fb_arbiter_if.slave  bus
);
    import t04_fb_pkg::*;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    owner_e            owner;
    logic              clr_busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_in_range;
    logic              disp_valid_q;
    logic              wr_drop_q;

    t04_fb_clear_seq #(
        .ADDR_W   (ADDR_W),
        .FB_WORDS (FB_WORDS)
    ) u_clear (
        .clk   (clk),
        .reset (reset),
        .go    (bus.clr_start),
        .stall (bus.disp_req),
        .busy  (clr_busy),
        .addr  (clr_addr),
        .we    (clr_we)
    );

    assign wr_in_range = (32'(bus.wr_addr) < FB_WORDS);

    // Fixed-priority grant; nobody owns the port while reset is held
    always_comb begin
        owner = OWN_NONE;
        if (!reset) begin
            if (bus.disp_req) begin
                owner = OWN_DISP;
            end else if (clr_we) begin
                owner = OWN_CLR;
            end else if (!clr_busy && bus.wr_req) begin
                owner = OWN_WR;
            end
        end
    end

    // RAM port and writer ack driven from the owner
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = ZERO_WORD;
        bus.wr_ack    = 1'b0;
        unique case (owner)
            OWN_DISP: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.disp_addr;
            end
            OWN_CLR: begin
                bus.mem_en   = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = clr_addr;
            end
            OWN_WR: begin
                // Out-of-range writes are acked but never reach the RAM
                bus.wr_ack = 1'b1;
                if (wr_in_range) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = bus.wr_addr;
                    bus.mem_wdata = bus.wr_data;
                end
            end
            default: ;
        endcase
    end

    // Read-return valid and sticky drop flag
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_valid_q <= 1'b0;
            wr_drop_q    <= 1'b0;
        end else begin
            disp_valid_q <= (owner == OWN_DISP);
            if (owner == OWN_WR && !wr_in_range) begin
                wr_drop_q <= 1'b1;
            end
        end
    end

    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_rdata = disp_valid_q ? bus.mem_rdata : ZERO_WORD;
    assign bus.clr_busy   = clr_busy;
    assign bus.wr_drop    = wr_drop_q;

endmodule

// File: doc/t04_fb_arbiter.md
Name: t04_fb_arbiter

Overview:
- Owns the single port of the pixel frame buffer and shares it between three requesters:
  - the display scan-out, which drives h_out/v_out/pixel_data timing and has a hard deadline;
  - the UART-driven pixel writer;
  - a button-triggered full-screen clear sequencer.
- Sits between the display/UART datapaths and the frame-buffer RAM inside t04_very_top.
- Display reads are never stalled. Clear and writes use leftover cycles.

Parameters:
- ADDR_W, 12, frame-buffer word address width.
- DATA_W, 8, frame-buffer word width (8 packed 1-bit pixels).
- FB_WORDS, 3072, number of valid words; addresses 0..FB_WORDS-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- disp_req  in  1  display read request for this cycle.
- disp_addr  in  ADDR_W  display read address.
- disp_valid  out  1  disp_rdata valid (read data return).
- disp_rdata  out  DATA_W  read data; 0 when disp_valid=0.
- wr_req  in  1  writer request; held until wr_ack.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  one-cycle pulse: request accepted.
- clr_start  in  1  pulse: begin full clear.
- clr_busy  out  1  clear in progress.
- wr_drop  out  1  sticky: an out-of-range write was dropped.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, one cycle after mem_en with mem_we=0.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, clear counter 0, wr_drop 0.
- Fixed priority per cycle: display > clear > writer. The grant is combinational from the current-cycle requests and state.
- Display grant:
  - mem_en=1, mem_we=0, mem_addr=disp_addr.
  - disp_valid asserts exactly one cycle later; disp_rdata=mem_rdata in that cycle.
  - Back-to-back display reads give back-to-back disp_valid.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_start; the counter loads 0 and clr_busy=1 from the next cycle.
  - In CLEAR, each cycle without disp_req writes 0 to address cnt (mem_en=1, mem_we=1, mem_wdata=0), then cnt++.
  - A cycle with disp_req stalls the counter.
  - After the write to FB_WORDS-1, CLEAR -> IDLE and clr_busy drops the next cycle.
  - clr_start while in CLEAR is ignored; no restart.
- Writer:
  - Granted only in IDLE with no disp_req.
  - On grant, wr_ack=1 in that same cycle. If wr_addr < FB_WORDS, then mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - If wr_addr >= FB_WORDS, the request is still acked, mem_en stays 0, and wr_drop sets (cleared only by reset).
  - No ack while clr_busy or while disp_req is high.
  - The requester must hold wr_addr/wr_data stable until ack.
- Simultaneous events:
  - clr_start and wr_req in the same IDLE cycle without disp_req: the writer is granted that cycle, and the clear starts the next cycle.
  - disp_req, wr_req and an active clear together: the display wins and both others wait.
- Idle cycle: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-clear: the FSM goes to IDLE, the counter to 0, and clr_busy to 0 the next cycle. The partially cleared buffer is acceptable. A pending disp_valid is squashed to 0.
- Width rules:
  - The counter is ADDR_W bits and compares against FB_WORDS-1.
  - FB_WORDS=2^ADDR_W is legal; the counter must terminate at FB_WORDS-1, not wrap to 0.

Decomposition:
- Package t04_fb_pkg holds:
  - the state enum (IDLE, CLEAR);
  - the owner enum (OWN_NONE, OWN_DISP, OWN_CLR, OWN_WR);
  - the constants FB_ADDR_W=12, FB_DATA_W=8, FB_WORDS=3072.
- The arbiter itself is one flat module.
- The clear sequencer (FSM + counter) is a natural sub-module: t04_fb_clear_seq, with inputs go/stall and outputs busy/addr/we.

Test Plan:
- Display only: disp_req=1 with addrs 0x000, 0x001, 0x002 on consecutive cycles, RAM preloaded 0xA5, 0x5A, 0xFF -> disp_valid high on cycles 1-3 with disp_rdata 0xA5, 0x5A, 0xFF; no stall.
- Writer contention: wr_req with addr 0x010, data 0x3C, and disp_req high for 3 cycles -> wr_ack held 0 for 3 cycles, pulses on cycle 4, mem write 0x3C@0x010 on cycle 4; later read of 0x010 returns 0x3C.
- Clear with display interleave: clr_start, and disp_req every 4th cycle -> 3072 zero writes, addresses strictly increasing 0..0xBFF with no gaps or repeats. clr_busy stays high for 3072 + number of stalled cycles, then drops; wr_req during the clear is not acked until clr_busy=0.
- Out-of-range write: wr_addr=0xC00 -> wr_ack pulses, mem_en=0, wr_drop=1 and stays 1 through subsequent valid writes.
- Simultaneous events: clr_start and wr_req in the same idle cycle -> writer acked that cycle, first clear write at address 0 the next cycle. clr_start re-pulsed at cnt=100 -> counter continues from 101.
- Reset mid-clear: assert reset at cnt=500 -> the next cycle has clr_busy=0, all mem_* outputs 0 and disp_valid=0. A new clr_start restarts from address 0.
